// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback grant encoding,
// used by the register file and by the writeback arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by writeback. Register 0 is never busy.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [REGS-1:0]       busy
);

    logic [REGS-1:0] set_mask;
    logic [REGS-1:0] clr_mask;
    logic [REGS-1:0] busy_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != '0)) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr_en && (clr_addr != '0)) begin
            clr_mask[clr_addr] = 1'b1;
        end
        // Clear before set so a same-edge reissue keeps the register busy.
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester (ALU, load) writeback arbiter with starvation guard and a
// registered register-file write port. WB_SCOREBOARD_EN adds the busy scoreboard.
module wb_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVELIMIT = 4,
    parameter int REGS        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aluvalid,
    output logic                  aluready,
    input  logic [REG_ADDR_W-1:0] aluaddr,
    input  logic [REG_DATA_W-1:0] aludata,
    input  logic                  memvalid,
    output logic                  memready,
    input  logic [REG_ADDR_W-1:0] memaddr,
    input  logic [REG_DATA_W-1:0] memdata,
    input  logic                  issuevalid,
    input  logic [REG_ADDR_W-1:0] issueaddr,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] writeaddr,
    output logic [REG_DATA_W-1:0] writedata,
    output logic [REGS-1:0]       busy
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVELIMIT);

    grant_e                grant;
    logic [3:0]            starve;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] xfer_addr;
    logic [REG_DATA_W-1:0] xfer_data;

    // Load data wins by default; a starved ALU overrides it for one grant.
    always_comb begin
        grant = GNT_NONE;
        if (!reset) begin
            if (aluvalid && (starve == STARVE_MAX)) begin
                grant = GNT_ALU;
            end else if (memvalid) begin
                grant = GNT_MEM;
            end else if (aluvalid) begin
                grant = GNT_ALU;
            end
        end
    end

    assign aluready  = (grant == GNT_ALU);
    assign memready  = (grant == GNT_MEM);
    assign xfer      = (grant != GNT_NONE);
    assign xfer_addr = (grant == GNT_MEM) ? memaddr : aluaddr;
    assign xfer_data = (grant == GNT_MEM) ? memdata : aludata;

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite  <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
            starve    <= '0;
        end else begin
            regwrite <= xfer && (xfer_addr != '0);
            if (xfer && (xfer_addr != '0)) begin
                writeaddr <= xfer_addr;
                writedata <= xfer_data;
            end
            if (!aluvalid || aluready) begin
                starve <= '0;
            end else if (starve != STARVE_MAX) begin
                starve <= starve + 4'd1;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    wb_scoreboard #(
        .REGS(REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issuevalid),
        .set_addr (issueaddr),
        .clr_en   (xfer),
        .clr_addr (xfer_addr),
        .busy     (busy)
    );
`else
    logic unused_issue;
    assign unused_issue = ^{issuevalid, issueaddr};
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected write-port results are queued as each
// step is driven and compared after the following rising edge.
module tb_wb_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aluvalid = 1'b0;
    logic        aluready;
    logic [4:0]  aluaddr = '0;
    logic [31:0] aludata = '0;
    logic        memvalid = 1'b0;
    logic        memready;
    logic [4:0]  memaddr = '0;
    logic [31:0] memdata = '0;
    logic        issuevalid = 1'b0;
    logic [4:0]  issueaddr = '0;
    logic        regwrite;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [31:0] busy;

    int total = 0;
    int bad = 0;

    logic [37:0] exp_q[$];
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] exp_busy = '0;

    wb_arbiter #(
        .STARVELIMIT(4),
        .REGS(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .aluvalid   (aluvalid),
        .aluready   (aluready),
        .aluaddr    (aluaddr),
        .aludata    (aludata),
        .memvalid   (memvalid),
        .memready   (memready),
        .memaddr    (memaddr),
        .memdata    (memdata),
        .issuevalid (issuevalid),
        .issueaddr  (issueaddr),
        .regwrite   (regwrite),
        .writeaddr  (writeaddr),
        .writedata  (writedata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check grants, queue the expected write-port
    // result, then compare it after the rising edge.
    task automatic applyStimulus(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic iv, input logic [4:0] ia,
        input grant_e exp_gnt, input string tag
    );
        logic [4:0]  xa;
        logic [31:0] xd;
        logic [37:0] e;
        logic [31:0] nb;
        @(negedge clk);
        aluvalid = av; aluaddr = aa; aludata = ad;
        memvalid = mv; memaddr = ma; memdata = md;
        issuevalid = iv; issueaddr = ia;
        #1;
        checkOutput({tag, ".aluready"}, 32'(aluready), 32'(exp_gnt == GNT_ALU));
        checkOutput({tag, ".memready"}, 32'(memready), 32'(exp_gnt == GNT_MEM));
        xa = (exp_gnt == GNT_MEM) ? ma : aa;
        xd = (exp_gnt == GNT_MEM) ? md : ad;
        if (exp_gnt != GNT_NONE && xa != 5'd0) begin
            exp_q.push_back({1'b1, xa, xd});
            last_addr = xa;
            last_data = xd;
        end else begin
            exp_q.push_back({1'b0, last_addr, last_data});
        end
        nb = exp_busy;
`ifdef WB_SCOREBOARD_EN
        if (exp_gnt != GNT_NONE && xa != 5'd0) nb[xa] = 1'b0;
        if (iv && ia != 5'd0) nb[ia] = 1'b1;
`endif
        exp_busy = nb;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput({tag, ".regwrite"}, 32'(regwrite), 32'(e[37]));
        checkOutput({tag, ".writeaddr"}, 32'(writeaddr), 32'(e[36:32]));
        checkOutput({tag, ".writedata"}, writedata, e[31:0]);
        checkOutput({tag, ".busy"}, busy, exp_busy);
    endtask

    task automatic doReset(input logic av, input string tag);
        @(negedge clk);
        reset = 1'b1;
        aluvalid = av;
        memvalid = 1'b0;
        issuevalid = 1'b0;
        #1;
        checkOutput({tag, ".aluready"}, 32'(aluready), 32'd0);
        checkOutput({tag, ".memready"}, 32'(memready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".regwrite"}, 32'(regwrite), 32'd0);
        checkOutput({tag, ".writeaddr"}, 32'(writeaddr), 32'd0);
        checkOutput({tag, ".writedata"}, writedata, 32'd0);
        checkOutput({tag, ".busy"}, busy, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        aluvalid = 1'b0;
        exp_q.delete();
        last_addr = '0;
        last_data = '0;
        exp_busy = '0;
    endtask

    initial begin
        $display("[TB] start");
        doReset(1'b0, "reset0");

        applyStimulus(1, 5, 32'h12345678, 0, 0, 0, 0, 0, GNT_ALU, "single_alu");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, GNT_NONE, "idle_hold");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, GNT_NONE, "issue9");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, GNT_MEM, $sformatf("contend%0d", i));
        end
        applyStimulus(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, GNT_ALU, "contend4");
        applyStimulus(0, 0, 0, 1, 4, 32'hB, 0, 0, GNT_MEM, "mem_after");

        applyStimulus(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, GNT_MEM, "zero_reg");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, GNT_NONE, "issue0");

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, GNT_NONE, "issue7");
        applyStimulus(1, 7, 32'h77, 0, 0, 0, 1, 7, GNT_ALU, "set_clr7");
        applyStimulus(1, 7, 32'h78, 0, 0, 0, 0, 0, GNT_ALU, "clr7");
        applyStimulus(1, 1, 32'h11, 0, 0, 0, 0, 0, GNT_ALU, "clr_idle1");

        applyStimulus(0, 0, 0, 1, 9, 32'h99, 0, 0, GNT_MEM, "clr9");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, GNT_NONE, "reissue7");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3, 32'hC, 1, 6, 32'hD, 0, 0, GNT_MEM, $sformatf("prestarve%0d", i));
        end
        doReset(1'b1, "reset_mid");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3, 32'hC, 1, 6, 32'hD, 0, 0, GNT_MEM, $sformatf("post_rst%0d", i));
        end
        applyStimulus(1, 3, 32'hC, 1, 6, 32'hD, 0, 0, GNT_ALU, "post_rst4");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, GNT_NONE, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
